// File: rtl/collect_buf_if.sv
// Handshake/bus bundle for collect_buf: burst capture side, status flags and read port.
// COLLECT_ACC_EN adds the acc_i mode bit sampled with arm_vi.
interface collect_buf_if #(
  parameter int y_w   = 32,
  parameter int depth = 8
);
  localparam int aw = (depth > 1) ? $clog2(depth) : 1;

  logic           arm_vi;
  logic [y_w-1:0] d_i;
  logic           v_vi;
  logic           busy_o;
  logic           done_vo;
  logic           ovf_o;
  logic [aw-1:0]  addr_r_i;
  logic           r_vi;
  logic [y_w-1:0] data_r_o;
  logic           r_vo;
`ifdef COLLECT_ACC_EN
  logic           acc_i;

  modport master (
    output arm_vi, d_i, v_vi, addr_r_i, r_vi, acc_i,
    input  busy_o, done_vo, ovf_o, data_r_o, r_vo
  );
  modport slave (
    input  arm_vi, d_i, v_vi, addr_r_i, r_vi, acc_i,
    output busy_o, done_vo, ovf_o, data_r_o, r_vo
  );
`else
  modport master (
    output arm_vi, d_i, v_vi, addr_r_i, r_vi,
    input  busy_o, done_vo, ovf_o, data_r_o, r_vo
  );
  modport slave (
    input  arm_vi, d_i, v_vi, addr_r_i, r_vi,
    output busy_o, done_vo, ovf_o, data_r_o, r_vo
  );
`endif
endinterface

// File: rtl/collect_buf.sv
// Collects one burst of depth results from a systolic column into a register file.
// Optional COLLECT_ACC_EN: per-burst accumulate mode (mem += d_i) for K-split partial sums.
module collect_buf #(
  parameter int y_w   = 32,
  parameter int depth = 8
) (
  input logic           clk_i,
  input logic           rst_i,
  collect_buf_if.slave  bus
);
  localparam int aw = (depth > 1) ? $clog2(depth) : 1;
  localparam int pw = $clog2(depth) + 1;

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t         state_reg;
  logic [pw-1:0]  ptr_reg;
  logic           busy_reg;
  logic           done_reg;
  logic           ovf_reg;
  logic [y_w-1:0] data_r_reg;
  logic           r_v_reg;

  logic [y_w-1:0] mem [0:depth-1];

  logic           wr_en;
  logic [aw-1:0]  wr_addr;
  logic [y_w-1:0] wr_data;

`ifdef COLLECT_ACC_EN
  logic acc_reg;
  logic acc_mode;
`endif

  // An arm cycle always targets entry 0, whatever ptr held before.
  always_comb begin
    wr_en   = bus.v_vi & (bus.arm_vi | (state_reg == COLLECT));
    wr_addr = bus.arm_vi ? '0 : ptr_reg[aw-1:0];
    wr_data = bus.d_i;
`ifdef COLLECT_ACC_EN
    acc_mode = bus.arm_vi ? bus.acc_i : acc_reg;
    if (acc_mode) begin
      wr_data = mem[wr_addr] + bus.d_i;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
`ifdef COLLECT_ACC_EN
      acc_reg   <= 1'b0;
`endif
    end else if (bus.arm_vi) begin
      ovf_reg <= 1'b0;
`ifdef COLLECT_ACC_EN
      acc_reg <= bus.acc_i;
`endif
      if (bus.v_vi) begin
        ptr_reg <= pw'(1);
        if (depth == 1) begin
          state_reg <= DONE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
        end else begin
          state_reg <= COLLECT;
          busy_reg  <= 1'b1;
          done_reg  <= 1'b0;
        end
      end else begin
        ptr_reg   <= '0;
        state_reg <= COLLECT;
        busy_reg  <= 1'b1;
        done_reg  <= 1'b0;
      end
    end else begin
      case (state_reg)
        COLLECT: begin
          if (bus.v_vi) begin
            ptr_reg <= ptr_reg + pw'(1);
            if (ptr_reg == pw'(depth - 1)) begin
              state_reg <= DONE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end
          end
        end
        default: begin
          if (bus.v_vi) begin
            ovf_reg <= 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read sees the pre-write contents on a same-address collision.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_r_reg <= '0;
      r_v_reg    <= 1'b0;
    end else begin
      r_v_reg <= bus.r_vi;
      if (bus.r_vi) begin
        data_r_reg <= (int'(bus.addr_r_i) < depth) ? mem[bus.addr_r_i] : '0;
      end
    end
  end

  assign bus.busy_o   = busy_reg;
  assign bus.done_vo  = done_reg;
  assign bus.ovf_o    = ovf_reg;
  assign bus.data_r_o = data_r_reg;
  assign bus.r_vo     = r_v_reg;
endmodule

// File: tb/tb_collect_buf.sv
// Self-checking bench for collect_buf against a burst-level reference model.
// Build with COLLECT_ACC_EN defined to also exercise accumulate mode.
module tb_collect_buf;
  localparam int YW    = 32;
  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  collect_buf_if #(.y_w(YW), .depth(DEPTH)) bus ();
  collect_buf #(.y_w(YW), .depth(DEPTH)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int total_cnt = 0;
  int pass_cnt  = 0;

  logic [YW-1:0] model_mem [DEPTH];
  int            model_cnt;
  bit            model_armed, model_ovf, model_acc;
  logic [YW-1:0] exp_rdata;
  bit            exp_rv, exp_busy, exp_done;

  // One clock of stimulus; the model is advanced by the burst rules, then outputs settle.
  task automatic drive(input bit arm, input bit v, input logic [YW-1:0] d,
                       input bit rv, input int addr, input bit acc);
    bus.arm_vi   = arm;
    bus.v_vi     = v;
    bus.d_i      = d;
    bus.r_vi     = rv;
    bus.addr_r_i = addr[AW-1:0];
`ifdef COLLECT_ACC_EN
    bus.acc_i    = acc;
`endif
    if (rv) begin
      exp_rv    = 1'b1;
      exp_rdata = (addr < DEPTH) ? model_mem[addr] : '0;
    end else begin
      exp_rv = 1'b0;
    end
    if (arm) begin
      model_ovf   = 1'b0;
      model_armed = 1'b1;
      model_cnt   = 0;
      model_acc   = acc;
      if (v) begin
        model_mem[0] = model_acc ? model_mem[0] + d : d;
        model_cnt    = 1;
      end
    end else if (model_armed && model_cnt < DEPTH) begin
      if (v) begin
        model_mem[model_cnt] = model_acc ? model_mem[model_cnt] + d : d;
        model_cnt++;
      end
    end else if (v) begin
      model_ovf = 1'b1;
    end
    exp_busy = model_armed && (model_cnt < DEPTH);
    exp_done = model_armed && (model_cnt == DEPTH);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.arm_vi = 1'b0; bus.v_vi = 1'b0; bus.d_i = '0; bus.r_vi = 1'b0; bus.addr_r_i = '0;
`ifdef COLLECT_ACC_EN
    bus.acc_i = 1'b0;
`endif
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    model_armed = 1'b0; model_cnt = 0; model_ovf = 1'b0; model_acc = 1'b0;
    exp_rdata = '0; exp_rv = 1'b0; exp_busy = 1'b0; exp_done = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    total_cnt++; if (bus.busy_o !== 1'b0) $display("FAIL reset_busy got=%0b exp=0", bus.busy_o); else pass_cnt++;
    total_cnt++; if (bus.done_vo !== 1'b0) $display("FAIL reset_done got=%0b exp=0", bus.done_vo); else pass_cnt++;
    total_cnt++; if (bus.ovf_o !== 1'b0) $display("FAIL reset_ovf got=%0b exp=0", bus.ovf_o); else pass_cnt++;
    total_cnt++; if (bus.r_vo !== 1'b0) $display("FAIL reset_rvo got=%0b exp=0", bus.r_vo); else pass_cnt++;
    total_cnt++; if (bus.data_r_o !== '0) $display("FAIL reset_data got=%h exp=0", bus.data_r_o); else pass_cnt++;
    $display("reset: busy=%0b done=%0b ovf=%0b", bus.busy_o, bus.done_vo, bus.ovf_o);
  endtask

  task automatic test_back_to_back();
    drive(1, 0, '0, 0, 0, 0);
    total_cnt++; if (bus.busy_o !== 1'b1) $display("FAIL b2b_arm_busy got=%0b exp=1", bus.busy_o); else pass_cnt++;
    for (int i = 1; i <= DEPTH; i++) begin
      drive(0, 1, YW'(i), 0, 0, 0);
      total_cnt++;
      if (bus.done_vo !== (i == DEPTH)) $display("FAIL b2b_done beat=%0d got=%0b exp=%0b", i, bus.done_vo, i == DEPTH);
      else pass_cnt++;
      $display("b2b beat %0d: d=%0d busy=%0b done=%0b", i, i, bus.busy_o, bus.done_vo);
    end
    for (int a = 0; a < DEPTH; a++) begin
      drive(0, 0, '0, 1, a, 0);
      total_cnt++;
      if (bus.r_vo !== 1'b1 || bus.data_r_o !== YW'(a + 1))
        $display("FAIL b2b_read addr=%0d got=%h/%0b exp=%h/1", a, bus.data_r_o, bus.r_vo, a + 1);
      else pass_cnt++;
      $display("b2b read addr %0d: data=%h rv=%0b", a, bus.data_r_o, bus.r_vo);
    end
    drive(0, 0, '0, 0, 0, 0);
    total_cnt++;
    if (bus.r_vo !== 1'b0 || bus.data_r_o !== YW'(DEPTH))
      $display("FAIL b2b_hold got=%h/%0b exp=%h/0", bus.data_r_o, bus.r_vo, DEPTH);
    else pass_cnt++;
  endtask

  task automatic test_bubbles();
    int n = 0;
    drive(1, 0, '0, 0, 0, 0);
    for (int c = 0; c < 4 * DEPTH && n < DEPTH; c++) begin
      bit v = (c % 2 == 1);
      drive(0, v, YW'(n + 1), 0, 0, 0);
      if (v) n++;
      total_cnt++;
      if (bus.busy_o !== exp_busy || bus.done_vo !== exp_done)
        $display("FAIL bubble_flags cyc=%0d got=%0b%0b exp=%0b%0b", c, bus.busy_o, bus.done_vo, exp_busy, exp_done);
      else pass_cnt++;
      $display("bubble cyc %0d: v=%0b busy=%0b done=%0b", c, v, bus.busy_o, bus.done_vo);
    end
    for (int a = 0; a < DEPTH; a++) begin
      drive(0, 0, '0, 1, a, 0);
      total_cnt++;
      if (bus.data_r_o !== YW'(a + 1)) $display("FAIL bubble_read addr=%0d got=%h exp=%h", a, bus.data_r_o, a + 1);
      else pass_cnt++;
    end
  endtask

  task automatic test_rearm();
    drive(1, 0, '0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, YW'(32'hAA + i), 0, 0, 0);
    drive(1, 0, '0, 0, 0, 0);
    total_cnt++; if (bus.busy_o !== 1'b1 || bus.done_vo !== 1'b0) $display("FAIL rearm_flags got=%0b%0b exp=10", bus.busy_o, bus.done_vo); else pass_cnt++;
    for (int i = 0; i < DEPTH; i++) drive(0, 1, YW'(32'h10 + i), 0, 0, 0);
    total_cnt++; if (bus.done_vo !== 1'b1) $display("FAIL rearm_done got=%0b exp=1", bus.done_vo); else pass_cnt++;
    for (int a = 0; a < DEPTH; a++) begin
      drive(0, 0, '0, 1, a, 0);
      total_cnt++;
      if (bus.data_r_o !== YW'(32'h10 + a)) $display("FAIL rearm_read addr=%0d got=%h exp=%h", a, bus.data_r_o, 32'h10 + a);
      else pass_cnt++;
      $display("rearm read addr %0d: data=%h", a, bus.data_r_o);
    end
  endtask

  task automatic test_ovf();
    drive(0, 1, 32'hDEADBEEF, 0, 0, 0);
    total_cnt++; if (bus.ovf_o !== 1'b1) $display("FAIL ovf_set got=%0b exp=1", bus.ovf_o); else pass_cnt++;
    total_cnt++; if (bus.done_vo !== 1'b1) $display("FAIL ovf_done got=%0b exp=1", bus.done_vo); else pass_cnt++;
    for (int a = 0; a < DEPTH; a++) begin
      drive(0, 0, '0, 1, a, 0);
      total_cnt++;
      if (bus.data_r_o !== YW'(32'h10 + a)) $display("FAIL ovf_contents addr=%0d got=%h exp=%h", a, bus.data_r_o, 32'h10 + a);
      else pass_cnt++;
    end
    total_cnt++; if (bus.ovf_o !== 1'b1) $display("FAIL ovf_sticky got=%0b exp=1", bus.ovf_o); else pass_cnt++;
    drive(1, 0, '0, 0, 0, 0);
    total_cnt++; if (bus.ovf_o !== 1'b0) $display("FAIL ovf_clear got=%0b exp=0", bus.ovf_o); else pass_cnt++;
    $display("ovf: cleared by arm, ovf=%0b busy=%0b", bus.ovf_o, bus.busy_o);
  endtask

  task automatic test_same_cycle();
    for (int i = 0; i < 5; i++) drive(0, 1, YW'(32'h50 + i), 0, 0, 0);
    drive(0, 1, 32'h55, 1, 5, 0);
    total_cnt++; if (bus.data_r_o !== 32'h15) $display("FAIL collide_old got=%h exp=15", bus.data_r_o); else pass_cnt++;
    drive(0, 0, '0, 1, 5, 0);
    total_cnt++; if (bus.data_r_o !== 32'h55) $display("FAIL collide_new got=%h exp=55", bus.data_r_o); else pass_cnt++;
    $display("collide: addr 5 new data=%h", bus.data_r_o);
    apply_reset();
    total_cnt++;
    if (bus.busy_o !== 1'b0 || bus.done_vo !== 1'b0) $display("FAIL midreset got=%0b%0b exp=00", bus.busy_o, bus.done_vo);
    else pass_cnt++;
  endtask

  task automatic test_arm_with_beat();
    drive(1, 1, 32'h77, 0, 0, 0);
    for (int i = 1; i < DEPTH; i++) drive(0, 1, YW'(32'h70 + i), 0, 0, 0);
    total_cnt++; if (bus.done_vo !== 1'b1) $display("FAIL armbeat_done got=%0b exp=1", bus.done_vo); else pass_cnt++;
    drive(0, 0, '0, 1, 0, 0);
    total_cnt++; if (bus.data_r_o !== 32'h77) $display("FAIL armbeat_e0 got=%h exp=77", bus.data_r_o); else pass_cnt++;
    drive(0, 0, '0, 1, DEPTH - 1, 0);
    total_cnt++; if (bus.data_r_o !== YW'(32'h70 + DEPTH - 1)) $display("FAIL armbeat_last got=%h", bus.data_r_o); else pass_cnt++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      bit arm = ($urandom_range(15) == 0);
      bit v   = $urandom_range(1);
      bit rv  = $urandom_range(1);
      int a   = $urandom_range(DEPTH - 1);
      bit acc = 1'b0;
`ifdef COLLECT_ACC_EN
      acc = $urandom_range(1);
`endif
      drive(arm, v, YW'($urandom), rv, a, acc);
      total_cnt++;
      if (bus.busy_o !== exp_busy || bus.done_vo !== exp_done || bus.ovf_o !== model_ovf ||
          bus.r_vo !== exp_rv || bus.data_r_o !== exp_rdata)
        $display("FAIL rand cyc=%0d got b%0b d%0b o%0b r%0b %h exp b%0b d%0b o%0b r%0b %h", c,
                 bus.busy_o, bus.done_vo, bus.ovf_o, bus.r_vo, bus.data_r_o,
                 exp_busy, exp_done, model_ovf, exp_rv, exp_rdata);
      else pass_cnt++;
      $display("rand cyc %0d: arm=%0b v=%0b rv=%0b addr=%0d data=%h", c, arm, v, rv, a, bus.data_r_o);
    end
  endtask

`ifdef COLLECT_ACC_EN
  task automatic test_acc();
    logic [YW-1:0] first_val [2] = '{32'h1, 32'hFFFFFFFF};
    logic [YW-1:0] want_val [2]  = '{32'h3, 32'h1};
    for (int k = 0; k < 2; k++) begin
      drive(1, 0, '0, 0, 0, 0);
      for (int i = 0; i < DEPTH; i++) drive(0, 1, first_val[k], 0, 0, 0);
      drive(1, 0, '0, 0, 0, 1);
      for (int i = 0; i < DEPTH; i++) drive(0, 1, 32'h2, 0, 0, 0);
      for (int a = 0; a < DEPTH; a++) begin
        drive(0, 0, '0, 1, a, 0);
        total_cnt++;
        if (bus.data_r_o !== want_val[k]) $display("FAIL acc_read pass=%0d addr=%0d got=%h exp=%h", k, a, bus.data_r_o, want_val[k]);
        else pass_cnt++;
        $display("acc pass %0d read addr %0d: data=%h", k, a, bus.data_r_o);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_bubbles();
    test_rearm();
    test_ovf();
    test_same_cycle();
    test_arm_with_beat();
`ifdef COLLECT_ACC_EN
    test_acc();
`endif
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
